// File: rtl/vsi_duty_sequencer.sv
// -----------------------------------------------------------------------------
// vsi_duty_sequencer
//
// Duty-cycle sequencer that sits in front of the PWM / dead-time stage of one
// voltage-source-inverter leg. It produces the duty word `d` and the gate
// enable. A new target duty arrives over a valid/ready handshake. `d` is then
// soft-ramped toward that target by a programmable step, once per carrier
// period. A protection fault forces zero duty with the gates off until the
// fault is explicitly acknowledged.
//
// `d` only changes on the edge that closes a carrier period, so the PWM
// counter never sees a duty update in the middle of a period. Fault entry and
// reset are the exceptions: both force d=0 immediately.
//
// Handshake: a target transfers on a rising clk edge where tgt_valid and
// tgt_ready are both 1. tgt_ready depends only on the current state and on
// `fault`; it never depends on tgt_valid. The accepted value is stored on that
// same edge.
//
// Optional feature (macro DUTY_CLAMP_EN):
//   When defined, parameters DMIN/DMAX are added. Accepted targets are clamped
//   into [DMIN,DMAX]. While running, the ramp starts at DMIN and never leaves
//   that window. A ramp-down with en=0 drops straight from <=DMIN to 0.
//   When undefined, the full 0..2^DW-1 range is used.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   en           run request (0 = ramp down and stop)
//   tgt          target duty
//   tgt_valid    target offered
//   tgt_ready    target can be accepted (combinational)
//   step         ramp increment per carrier period (0 behaves as 1)
//   fault        level fault from protection
//   fault_clr    fault acknowledge pulse
//   d            duty word to PWM (registered)
//   gate_en      gate drivers may switch (registered)
//   state        00 IDLE, 01 RAMP, 10 HOLD, 11 FAULT (registered)
//   period_tick  one-cycle pulse in the last cycle of each carrier period
// -----------------------------------------------------------------------------
module vsi_duty_sequencer #(
   parameter int DW     = 10,
   parameter int PERIOD = 1024,
   parameter int SW     = 6
`ifdef DUTY_CLAMP_EN
   ,
   parameter int DMIN   = 16,
   parameter int DMAX   = 1007
`endif
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          en,
   input  logic [DW-1:0] tgt,
   input  logic          tgt_valid,
   output logic          tgt_ready,
   input  logic [SW-1:0] step,
   input  logic          fault,
   input  logic          fault_clr,
   output logic [DW-1:0] d,
   output logic          gate_en,
   output logic [1:0]    state,
   output logic          period_tick
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RAMP  = 2'b01,
      ST_HOLD  = 2'b10,
      ST_FAULT = 2'b11
   } state_e;

   localparam int CW = (PERIOD > 2) ? $clog2(PERIOD) : 2;
   localparam logic [CW-1:0] CNT_LAST = CW'(PERIOD - 1);
   localparam logic [CW-1:0] CNT_PRE  = CW'(PERIOD - 2);

`ifdef DUTY_CLAMP_EN
   localparam logic [DW-1:0] DMIN_W = DW'(DMIN);
   localparam logic [DW-1:0] DMAX_W = DW'(DMAX);

   function automatic logic [DW-1:0] clamp_duty(input logic [DW-1:0] v);
      if (v < DMIN_W) begin
         return DMIN_W;
      end else if (v > DMAX_W) begin
         return DMAX_W;
      end else begin
         return v;
      end
   endfunction
`endif

   state_e          state_r;
   logic [DW-1:0]   d_r;
   logic            gate_r;
   logic [DW-1:0]   tgt_r;
   logic [CW-1:0]   cnt;
   logic            tick_r;

   logic            hs;
   logic [DW-1:0]   tgt_in;
   logic [DW-1:0]   tgt_eff;
   logic [DW:0]     step_ext;
   logic [DW:0]     d_ext;
   logic [DW:0]     t_ext;
   logic [DW:0]     diff;
   logic            going_up;
   logic [DW-1:0]   ramp_d;
   logic            ramp_done;
   logic            ramp_idle;

   assign tgt_ready   = ((state_r == ST_IDLE) || (state_r == ST_HOLD)) && !fault;
   assign hs          = tgt_valid && tgt_ready;
   assign d           = d_r;
   assign gate_en     = gate_r;
   assign state       = state_r;
   assign period_tick = tick_r;

   // Value that gets stored on a handshake, and the target the ramp steers to.
   // A stopped leg always ramps toward zero, whatever was last accepted.
`ifdef DUTY_CLAMP_EN
   assign tgt_in  = clamp_duty(tgt);
   assign tgt_eff = en ? clamp_duty(tgt_r) : '0;
`else
   assign tgt_in  = tgt;
   assign tgt_eff = en ? tgt_r : '0;
`endif

   // A step of 0 would stall the ramp forever, so it behaves as 1.
   assign step_ext = (step == '0) ? (DW+1)'(1) : (DW+1)'(step);

   // Distance to target in DW+1 bits, so the subtraction cannot wrap.
   always_comb begin
      d_ext    = {1'b0, d_r};
      t_ext    = {1'b0, tgt_eff};
      going_up = (t_ext > d_ext);
      diff     = going_up ? (t_ext - d_ext) : (d_ext - t_ext);
   end

   // Duty value to apply at the next period boundary while ramping.
   // When the remaining distance exceeds the step, adding or subtracting the
   // step cannot leave 0..2^DW-1. The target lies beyond d + step, so the
   // result never overshoots and never wraps.
   always_comb begin
      ramp_d    = d_r;
      ramp_done = 1'b0;
`ifdef DUTY_CLAMP_EN
      if (en && (d_r < DMIN_W)) begin
         // Leaving zero: jump straight to the minimum pulse width.
         ramp_d    = DMIN_W;
         ramp_done = (tgt_eff == DMIN_W);
      end else if (!en && (d_r <= DMIN_W)) begin
         // Stopping: pulses below the minimum are skipped entirely.
         ramp_d    = '0;
         ramp_done = 1'b1;
      end else
`endif
      if (diff <= step_ext) begin
         ramp_d    = tgt_eff;
         ramp_done = 1'b1;
      end else if (going_up) begin
         ramp_d    = DW'(d_ext + step_ext);
      end else begin
         ramp_d    = DW'(d_ext - step_ext);
      end
      ramp_idle = ramp_done && !en && (tgt_eff == '0);
   end

   // The period counter free-runs in every state, including FAULT.
   // tick_r is registered one count early, so it is high exactly in the
   // cycle where the count equals PERIOD-1.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt    <= '0;
         tick_r <= 1'b0;
      end else begin
         if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
         tick_r <= (cnt == CNT_PRE);
      end
   end

   // Sequencer FSM. Fault has priority over every other event, including a
   // coincident handshake or period tick.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         d_r     <= '0;
         gate_r  <= 1'b0;
         tgt_r   <= '0;
      end else if (fault) begin
         state_r <= ST_FAULT;
         d_r     <= '0;
         gate_r  <= 1'b0;
         tgt_r   <= '0;
      end else begin
         if (hs) begin
            tgt_r <= tgt_in;
         end
         case (state_r)
            ST_IDLE: begin
               d_r    <= '0;
               gate_r <= 1'b0;
               if (en) begin
                  state_r <= ST_RAMP;
                  gate_r  <= 1'b1;
               end
            end
            ST_RAMP: begin
               if (tick_r) begin
                  d_r <= ramp_d;
                  if (ramp_done) begin
                     if (ramp_idle) begin
                        state_r <= ST_IDLE;
                        gate_r  <= 1'b0;
                     end else begin
                        state_r <= ST_HOLD;
                     end
                  end
               end
            end
            ST_HOLD: begin
               // A stop request restarts the ramp toward zero, even if the
               // same edge also accepts a new target.
               if (!en || (hs && (tgt_in != d_r))) begin
                  state_r <= ST_RAMP;
               end
            end
            ST_FAULT: begin
               d_r    <= '0;
               gate_r <= 1'b0;
               // fault is known to be 0 in this branch.
               if (fault_clr) begin
                  state_r <= ST_IDLE;
               end
            end
            default: begin
               state_r <= ST_IDLE;
               d_r     <= '0;
               gate_r  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_vsi_duty_sequencer.sv
// -----------------------------------------------------------------------------
// tb_vsi_duty_sequencer
//
// Directed bench for vsi_duty_sequencer, built with a short carrier period.
// Drivers push the expected {state, gate_en, d} snapshots into exp_q. A
// monitor pops one entry on every change of those outputs and compares it.
// Direct checks cover reset values, tgt_ready and period-tick timing.
// Builds with DUTY_CLAMP_EN defined run the clamp sequence instead of the
// default ramp/fault sequence.
// -----------------------------------------------------------------------------
module tb_vsi_duty_sequencer;

   localparam int DW = 10;
   localparam int SW = 6;
   localparam int P  = 32;
   localparam logic [1:0] S_IDLE  = 2'b00;
   localparam logic [1:0] S_RAMP  = 2'b01;
   localparam logic [1:0] S_HOLD  = 2'b10;
   localparam logic [1:0] S_FAULT = 2'b11;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          en;
   logic [DW-1:0] tgt;
   logic          tgt_valid;
   logic          tgt_ready;
   logic [SW-1:0] step;
   logic          fault;
   logic          fault_clr;
   logic [DW-1:0] d;
   logic          gate_en;
   logic [1:0]    state;
   logic          period_tick;

   logic [DW+2:0] exp_q[$];
   int            n_cmp  = 0;
   int            n_err  = 0;
   bit            mon_on = 1'b0;

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   vsi_duty_sequencer #(.DW(DW), .PERIOD(P), .SW(SW)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .en          (en),
      .tgt         (tgt),
      .tgt_valid   (tgt_valid),
      .tgt_ready   (tgt_ready),
      .step        (step),
      .fault       (fault),
      .fault_clr   (fault_clr),
      .d           (d),
      .gate_en     (gate_en),
      .state       (state),
      .period_tick (period_tick)
   );

   // ---------------- helpers ----------------
   task automatic push(input logic [1:0] s, input logic g, input logic [DW-1:0] v);
      exp_q.push_back({s, g, v});
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   // Wait until every queued snapshot has been seen, within a cycle budget.
   task automatic drain(input string name, input int max_cyc);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < max_cyc) begin
         @(negedge clk);
         k++;
      end
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL %s: %0d expected outputs never appeared, expected 0 outstanding",
                  name, exp_q.size());
         exp_q.delete();
      end
   endtask

   // Count negedges until period_tick is seen high (bounded).
   task automatic ticks_until(output int k);
      k = 0;
      do begin
         @(negedge clk);
         k++;
      end while (!period_tick && k < 4*P);
   endtask

   // ---------------- monitor / scoreboard ----------------
   initial begin
      logic [DW+2:0] e;
      forever begin
         @(state or gate_en or d);
         if (mon_on) begin
            #1;
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_err++;
               $display("FAIL unexpected_change: got state=%0d gate_en=%0d d=%0d, expected no change",
                        state, gate_en, d);
            end else begin
               e = exp_q.pop_front();
               if ({state, gate_en, d} !== e) begin
                  n_err++;
                  $display("FAIL out_seq: got state=%0d gate_en=%0d d=%0d, expected state=%0d gate_en=%0d d=%0d",
                           state, gate_en, d, e[DW+2:DW+1], e[DW], e[DW-1:0]);
               end
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      int k;
      rst_n     = 1'b0;
      en        = 1'b0;
      tgt       = '0;
      tgt_valid = 1'b0;
      step      = '0;
      fault     = 1'b0;
      fault_clr = 1'b0;

      // Reset values.
      repeat (2) @(negedge clk);
      check("rst_d", d, 0);
      check("rst_gate_en", gate_en, 0);
      check("rst_state", state, S_IDLE);
      check("rst_period_tick", period_tick, 0);
      check("rst_tgt_ready", tgt_ready, 1);

      rst_n  = 1'b1;
      mon_on = 1'b1;
      ticks_until(k);
      check("first_tick_cycles", k, P-1);
      ticks_until(k);
      check("period_cycles", k, P);

`ifndef DUTY_CLAMP_EN
      // Ramp up 0 -> 100 with step 8: 8..96 then 100, thirteen ticks.
      push(S_RAMP, 1'b1, 0);
      for (int v = 8; v <= 96; v += 8) push(S_RAMP, 1'b1, DW'(v));
      push(S_HOLD, 1'b1, 100);
      tgt = 100; tgt_valid = 1'b1; step = 8; en = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      drain("ramp_up", 15*P);

      // Ramp down to stop with step 30: 70, 40, 10, then 0 together with IDLE.
      push(S_RAMP, 1'b1, 100);
      push(S_RAMP, 1'b1, 70);
      push(S_RAMP, 1'b1, 40);
      push(S_RAMP, 1'b1, 10);
      push(S_IDLE, 1'b0, 0);
      step = 30; en = 1'b0;
      drain("ramp_down", 6*P);

      // Step 0 behaves as 1. Offer 500 while ramping: refused until HOLD,
      // then accepted and the ramp restarts toward 500.
      push(S_RAMP, 1'b1, 0);
      for (int v = 1; v < 100; v++) push(S_RAMP, 1'b1, DW'(v));
      push(S_HOLD, 1'b1, 100);
      push(S_RAMP, 1'b1, 100);
      for (int v = 101; v <= 300; v++) push(S_RAMP, 1'b1, DW'(v));
      step = 0; en = 1'b1;
      @(negedge clk);
      tgt = 500; tgt_valid = 1'b1;
      #1 check("ready_low_in_ramp", tgt_ready, 0);
      drain("ramp_step0", 310*P);

      // Fault mid-period at d=300, with a target offered on the same cycle.
      repeat (4) @(negedge clk);
      push(S_FAULT, 1'b0, 0);
      fault = 1'b1; tgt = 700;
      #1 check("ready_low_on_fault", tgt_ready, 0);
      @(posedge clk);
      #1;
      check("fault_state", state, S_FAULT);
      check("fault_d", d, 0);
      check("fault_gate_en", gate_en, 0);
      @(negedge clk);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      check("clr_ignored_while_fault", state, S_FAULT);
      ticks_until(k);
      check("tick_runs_in_fault", (k <= P), 1);
      @(negedge clk);
      fault = 1'b0; tgt_valid = 1'b0; en = 1'b0;
      @(negedge clk);
      check("fault_stays_without_clr", state, S_FAULT);
      push(S_IDLE, 1'b0, 0);
      fault_clr = 1'b1;
      @(negedge clk);
      fault_clr = 1'b0;
      drain("fault_clear", 4);

      // The stored target was cleared by the fault: a restart settles at d=0.
      push(S_RAMP, 1'b1, 0);
      push(S_HOLD, 1'b1, 0);
      step = 5; en = 1'b1;
      drain("tgt_cleared", 3*P);

      // Handshake in HOLD on the same edge en falls: store 200 but ramp to 0.
      push(S_RAMP, 1'b1, 0);
      push(S_IDLE, 1'b0, 0);
      tgt = 200; tgt_valid = 1'b1; en = 1'b0;
      #1 check("ready_high_in_hold", tgt_ready, 1);
      @(negedge clk);
      tgt_valid = 1'b0;
      drain("hs_with_en_fall", 3*P);

      // Re-enable: the 200 stored above now drives the ramp.
      push(S_RAMP, 1'b1, 0);
      push(S_RAMP, 1'b1, 5);
      push(S_RAMP, 1'b1, 10);
      push(S_RAMP, 1'b1, 15);
      en = 1'b1;
      drain("stored_tgt_used", 5*P);

      // Asynchronous reset mid-period, between clock edges.
      repeat (3) @(negedge clk);
      push(S_IDLE, 1'b0, 0);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_d", d, 0);
      check("async_rst_gate_en", gate_en, 0);
      check("async_rst_state", state, S_IDLE);
      en = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      ticks_until(k);
      check("counter_restart", k, P-1);
      drain("async_rst", 2);
`else
      // Clamp: tgt=3 is stored as 16; the first tick jumps straight to 16.
      push(S_RAMP, 1'b1, 0);
      push(S_HOLD, 1'b1, 16);
      tgt = 3; tgt_valid = 1'b1; step = 63; en = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      drain("clamp_low", 3*P);

      // Stop from d=16: the next tick goes straight to 0 and IDLE.
      push(S_RAMP, 1'b1, 16);
      push(S_IDLE, 1'b0, 0);
      en = 1'b0;
      drain("clamp_stop", 3*P);

      // tgt=1020 is stored as 1007: 16, 79, ... then 1007 in HOLD.
      begin
         int v;
         push(S_RAMP, 1'b1, 0);
         v = 16;
         push(S_RAMP, 1'b1, DW'(v));
         while (1007 - v > 63) begin
            v += 63;
            push(S_RAMP, 1'b1, DW'(v));
         end
         push(S_HOLD, 1'b1, 1007);
      end
      tgt = 1020; tgt_valid = 1'b1; en = 1'b1;
      @(negedge clk);
      tgt_valid = 1'b0;
      drain("clamp_high", 20*P);
      check("clamp_high_d", d, 1007);
`endif

      repeat (4) @(negedge clk);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
